// File: rtl/voice_allocator.sv
// voice_allocator: maps MIDI note-on/note-off bursts onto NUM_VOICES voice slots.
// Optional macro VOICE_STEAL_EN: when all voices are busy, steal the oldest; otherwise drop the note-on.
// Latency off+on+1 cycles from burst_ready_in to update_out; bursts arriving while busy are dropped.

module voice_allocator #(
  parameter int NUM_VOICES = 5,
  parameter int AGE_W      = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [4:0][20:0]            burst_notes_on_in,
  input  logic [4:0][20:0]            burst_notes_off_in,
  input  logic [2:0]                  on_msg_count_in,
  input  logic [2:0]                  off_msg_count_in,
  input  logic                        burst_ready_in,
  output logic [NUM_VOICES-1:0][7:0]  voice_note_out,
  output logic [NUM_VOICES-1:0][7:0]  voice_velocity_out,
  output logic [NUM_VOICES-1:0][3:0]  voice_channel_out,
  output logic [NUM_VOICES-1:0]       voice_active_out,
  output logic                        update_out,
  output logic                        busy_out,
  output logic                        dropped_out
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFF_SCAN = 2'd1,
    ON_ALLOC = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  // On messages keep {channel, note, velocity}; off messages only need {channel, note}.
  logic [4:0][19:0]               on_msgs_q, on_msgs_d;
  logic [4:0][11:0]               off_msgs_q, off_msgs_d;
  logic [2:0]                     on_cnt_q, on_cnt_d;
  logic [2:0]                     off_cnt_q, off_cnt_d;
  logic [2:0]                     on_idx_q, on_idx_d;
  logic [2:0]                     off_idx_q, off_idx_d;
  logic [NUM_VOICES-1:0][7:0]     note_q, note_d;
  logic [NUM_VOICES-1:0][7:0]     vel_q, vel_d;
  logic [NUM_VOICES-1:0][3:0]     chan_q, chan_d;
  logic [NUM_VOICES-1:0]          active_q, active_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
  logic                           update_q, update_d;
  logic                           busy_q, busy_d;
  logic                           dropped_q, dropped_d;

  // Combinational scratch for the current message.
  logic [19:0]                    cur_on;
  logic [11:0]                    cur_off;
  logic [2:0]                     on_idx_nxt, off_idx_nxt;
  logic [2:0]                     on_cnt_in, off_cnt_in;
  logic                           hit_found, free_found;
  logic [IDX_W-1:0]               hit_idx, free_idx, wr_idx;
  logic                           do_write;
  logic                           rel_en;
  logic [7:0]                     rel_note;
  logic [3:0]                     rel_chan;
  logic [4:0]                     unused_status;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]               steal_idx;
  logic [AGE_W-1:0]               best_age;
`endif

  // Status bits and off-message velocities carry no information for allocation.
  always_comb begin
    unused_status = '0;
    for (int i = 0; i < 5; i++) begin
      unused_status[i] = burst_notes_on_in[i][20] ^ burst_notes_off_in[i][20]
                         ^ (^burst_notes_off_in[i][7:0]);
    end
  end

  // Next-state logic: capture, off scan, on allocation and voice table update.
  always_comb begin
    state_d    = state_q;
    on_msgs_d  = on_msgs_q;
    off_msgs_d = off_msgs_q;
    on_cnt_d   = on_cnt_q;
    off_cnt_d  = off_cnt_q;
    on_idx_d   = on_idx_q;
    off_idx_d  = off_idx_q;
    note_d     = note_q;
    vel_d      = vel_q;
    chan_d     = chan_q;
    active_d   = active_q;
    age_d      = age_q;
    dropped_d  = 1'b0;

    on_cnt_in   = (on_msg_count_in  > 3'd5) ? 3'd5 : on_msg_count_in;
    off_cnt_in  = (off_msg_count_in > 3'd5) ? 3'd5 : off_msg_count_in;
    cur_on      = on_msgs_q[on_idx_q];
    cur_off     = off_msgs_q[off_idx_q];
    on_idx_nxt  = on_idx_q + 3'd1;
    off_idx_nxt = off_idx_q + 3'd1;

    rel_en   = 1'b0;
    rel_note = cur_off[7:0];
    rel_chan = cur_off[11:8];
    do_write = 1'b0;
    wr_idx   = '0;

    // Candidate voices for the current on message: existing match, then lowest free.
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit_found && active_q[i] && note_q[i] == cur_on[15:8]
          && chan_q[i] == cur_on[19:16]) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
`ifdef VOICE_STEAL_EN
    // Oldest voice; strict compare keeps the lowest index on ties.
    steal_idx = '0;
    best_age  = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > best_age) begin
        best_age  = age_q[i];
        steal_idx = IDX_W'(i);
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (burst_ready_in) begin
          for (int i = 0; i < 5; i++) begin
            on_msgs_d[i]  = burst_notes_on_in[i][19:0];
            off_msgs_d[i] = burst_notes_off_in[i][19:8];
          end
          on_cnt_d  = on_cnt_in;
          off_cnt_d = off_cnt_in;
          on_idx_d  = 3'd0;
          off_idx_d = 3'd0;
          // Empty lists are skipped without spending a cycle on them.
          if (off_cnt_in != 3'd0)     state_d = OFF_SCAN;
          else if (on_cnt_in != 3'd0) state_d = ON_ALLOC;
          else                        state_d = DONE;
        end
      end
      OFF_SCAN: begin
        rel_en    = 1'b1;
        off_idx_d = off_idx_nxt;
        if (off_idx_nxt == off_cnt_q) begin
          state_d = (on_cnt_q != 3'd0) ? ON_ALLOC : DONE;
        end
      end
      ON_ALLOC: begin
        if (cur_on[7:0] == 8'd0) begin
          // Zero velocity is a note-off in disguise.
          rel_en   = 1'b1;
          rel_note = cur_on[15:8];
          rel_chan = cur_on[19:16];
        end else if (hit_found) begin
          do_write = 1'b1;
          wr_idx   = hit_idx;
        end else if (free_found) begin
          do_write = 1'b1;
          wr_idx   = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          do_write = 1'b1;
          wr_idx   = steal_idx;
`else
          dropped_d = 1'b1;
`endif
        end
        on_idx_d = on_idx_nxt;
        if (on_idx_nxt == on_cnt_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Release every sounding voice with matching note and channel.
    if (rel_en) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (active_q[i] && note_q[i] == rel_note && chan_q[i] == rel_chan) begin
          active_d[i] = 1'b0;
        end
      end
    end

    // Claim the chosen voice; every other sounding voice grows older.
    if (do_write) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == wr_idx) begin
          note_d[i]   = cur_on[15:8];
          chan_d[i]   = cur_on[19:16];
          vel_d[i]    = cur_on[7:0];
          active_d[i] = 1'b1;
          age_d[i]    = '0;
        end else if (active_q[i] && age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end

    if (state_q != IDLE && burst_ready_in) dropped_d = 1'b1;
    busy_d   = (state_d != IDLE);
    update_d = (state_d == DONE);
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      on_msgs_q  <= '0;
      off_msgs_q <= '0;
      on_cnt_q   <= '0;
      off_cnt_q  <= '0;
      on_idx_q   <= '0;
      off_idx_q  <= '0;
      note_q     <= '0;
      vel_q      <= '0;
      chan_q     <= '0;
      active_q   <= '0;
      age_q      <= '0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      on_msgs_q  <= on_msgs_d;
      off_msgs_q <= off_msgs_d;
      on_cnt_q   <= on_cnt_d;
      off_cnt_q  <= off_cnt_d;
      on_idx_q   <= on_idx_d;
      off_idx_q  <= off_idx_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      chan_q     <= chan_d;
      active_q   <= active_d;
      age_q      <= age_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign voice_note_out     = note_q;
  assign voice_velocity_out = vel_q;
  assign voice_channel_out  = chan_q;
  assign voice_active_out   = active_q;
  assign update_out         = update_q;
  assign busy_out           = busy_q;
  assign dropped_out        = dropped_q;

endmodule
